multicycle_control: RTL and testbench
=====================================

# multicycle_control

Sequencing FSM for the multicycle MIPS core, replacing the single-cycle control decoder. It steps the shared datapath (PC, unified memory, IR, register file, ALU, ALUOut) through fetch, decode, execute, memory and writeback. It supports memory wait-states and a blocking syscall handshake.

## Interface
- No parameters; opcode/funct/state encodings come from `mips.h`.
- clock  in  1  system clock, all state changes on rising edge
- reset  in  1  asynchronous, active-high; forces state IDLE
- opcode  in  6  IR[31:26], held stable by datapath IR
- funct  in  6  IR[5:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes access this cycle
- syscall_done  in  1  syscall unit finished
- pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write  out  1 each  enables
- i_or_d  out  1  0 = PC addresses memory, 1 = ALUOut
- reg_dst  out  1  0 = rt, 1 = rd
- mem_to_reg  out  1  0 = ALUOut, 1 = MDR
- jal_link  out  1  write PC into $31
- alu_src_a  out  1  0 = PC, 1 = A
- alu_src_b  out  2  0 = B, 1 = const 4, 2 = sign-ext imm, 3 = sign-ext imm<<2
- alu_op  out  2  0 add, 1 sub, 2 decode funct
- pc_source  out  2  0 ALU result, 1 ALUOut, 2 jump addr, 3 $ra/rs
- syscall_req  out  1  syscall pending
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state, for debug/$monitor

## Operation
- States: IDLE 0, FETCH 1, DECODE 2, MEMADR 3, MEMRD 4, MEMWB 5, MEMWR 6, REX 7, RWB 8, BRANCH 9, JUMP 10, IEX 11, IWB 12, JR 13, SYSCALL 14.
- IDLE -> FETCH unconditionally; all outputs 0.
- FETCH: mem_read, i_or_d=0, src_a=0, src_b=1, op add, pc_source=0. ir_write and pc_write equal mem_ready. Stay while !mem_ready, else -> DECODE.
- DECODE: src_a=0, src_b=3, op add. Next state by opcode:
  - lw 0x23 / sw 0x2B -> MEMADR
  - R-type 0x00 -> JR if funct 0x08, SYSCALL if 0x0C, else REX
  - beq 0x04 -> BRANCH
  - addi 0x08 -> IEX
  - j 0x02 / jal 0x03 -> JUMP
  - any other opcode: pulse illegal_op -> FETCH
- MEMADR: src_a=1, src_b=2, op add; -> MEMRD (lw) or MEMWR (sw).
- MEMRD: mem_read, i_or_d=1; hold until mem_ready -> MEMWB.
- MEMWB: reg_write, mem_to_reg=1, reg_dst=0 -> FETCH.
- MEMWR: mem_write, i_or_d=1; hold until mem_ready -> FETCH.
- REX: src_a=1, src_b=0, op funct -> RWB. RWB: reg_write, reg_dst=1 -> FETCH.
- IEX: src_a=1, src_b=2, op add -> IWB. IWB: reg_write, reg_dst=0 -> FETCH.
- BRANCH: src_a=1, src_b=0, op sub, pc_write_cond, pc_source=1 -> FETCH.
- JUMP: pc_write, pc_source=2; for jal also reg_write + jal_link -> FETCH.
- JR: pc_write, pc_source=3 -> FETCH.
- SYSCALL: syscall_req held high until syscall_done=1, then -> FETCH.
- All unlisted outputs are 0 in every state.

## Timing
- Moore outputs decoded from the state register. Exceptions are Mealy on mem_ready: FETCH ir_write/pc_write.
- CPI with zero wait-states: lw 5, sw 4, R-type/addi 4, beq/j/jal/jr 3, syscall 3 + wait.
- Each memory wait cycle adds exactly 1 cycle, with mem_read/mem_write and i_or_d held constant.
- syscall_done arriving in the same cycle syscall_req first rises is honoured: leave SYSCALL next edge. syscall_done outside SYSCALL is ignored.
- reset asserted at any time: state=IDLE immediately (asynchronous), all outputs 0 in the same delta, including an in-flight mem_write.
- After reset deasserts: IDLE for one edge, first FETCH on the next.
- State encoding 15: unreachable; decodes as IDLE, next state FETCH.

## Structure
- `mips.h` gains state codes and opcode/funct defines (OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J, OP_JAL, FN_JR, FN_SYSCALL). No local literals.
- One sub-module: `mc_output_decode`, combinational state+opcode+mem_ready -> control outputs. The top holds only the state register and next-state logic.

## Test plan
- Reset then lw, mem_ready always 1: states 0,1,2,3,4,5,1. reg_write and mem_to_reg are high only in state 5.
- sw with mem_ready low for 2 cycles in MEMWR: mem_write=1, i_or_d=1 for 3 cycles, then FETCH.
- beq: BRANCH shows alu_op=1, pc_write_cond=1, pc_source=1. Total 3 cycles; zero has no effect on the state path.
- jal: JUMP shows pc_write=1, pc_source=2, reg_write=1, jal_link=1. jr (funct 0x08): JR shows pc_source=3.
- syscall with syscall_done after 4 cycles: syscall_req high exactly 4 cycles, then FETCH. Opcode 0x3F: illegal_op pulses 1 cycle in DECODE, then FETCH.
- reset asserted mid-MEMWR at a non-edge time: mem_write falls immediately, state=0. Recovery reaches FETCH after one edge.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle MIPS control FSM: state codes,
// opcode/funct values and the mux-select codes driven onto the datapath.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_FETCH   = 4'd1,
    S_DECODE  = 4'd2,
    S_MEMADR  = 4'd3,
    S_MEMRD   = 4'd4,
    S_MEMWB   = 4'd5,
    S_MEMWR   = 4'd6,
    S_REX     = 4'd7,
    S_RWB     = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10,
    S_IEX     = 4'd11,
    S_IWB     = 4'd12,
    S_JR      = 4'd13,
    S_SYSCALL = 4'd14
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_SYSCALL = 6'h0C;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;

  localparam logic [1:0] SRCB_REG  = 2'd0;  // B register
  localparam logic [1:0] SRCB_FOUR = 2'd1;  // PC increment
  localparam logic [1:0] SRCB_IMM  = 2'd2;  // sign-extended immediate
  localparam logic [1:0] SRCB_BOFF = 2'd3;  // sign-extended immediate << 2

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;
  localparam logic [1:0] PCSRC_REG    = 2'd3;

  // Opcodes this core implements; anything else traps as illegal in DECODE.
  function automatic logic op_legal(input logic [5:0] op);
    return op inside {OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW};
  endfunction

endpackage

// File: rtl/multicycle_control_output_decode.sv
// mc_output_decode: combinational control-word decode for the multicycle FSM.
// Inputs : state (current FSM state), opcode (IR[31:26]), mem_ready.
// Outputs: datapath enables and mux selects. All Moore on state except the
//          FETCH ir_write/pc_write, which follow mem_ready.
module mc_output_decode
  import multicycle_control_pkg::*;
(
  input  state_t      state,
  input  logic [5:0]  opcode,
  input  logic        mem_ready,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        jal_link,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        syscall_req,
  output logic        illegal_op
);

  always_comb begin
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    reg_write     = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    jal_link      = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    alu_op        = ALU_ADD;
    pc_source     = PCSRC_ALU;
    syscall_req   = 1'b0;
    illegal_op    = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = SRCB_FOUR;
        // IR and PC only commit on the cycle the fetch completes.
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      S_DECODE: begin
        // Speculative branch target into ALUOut.
        alu_src_b  = SRCB_BOFF;
        illegal_op = !op_legal(opcode);
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_REX: begin
        alu_src_a = 1'b1;
        alu_op    = ALU_FUNCT;
      end
      S_RWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      S_IEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
      end
      S_IWB: reg_write = 1'b1;
      S_BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_JUMP;
        if (opcode == OP_JAL) begin
          reg_write = 1'b1;
          jal_link  = 1'b1;
        end
      end
      S_JR: begin
        pc_write  = 1'b1;
        pc_source = PCSRC_REG;
      end
      S_SYSCALL: syscall_req = 1'b1;
      default: ;  // IDLE and the unused code 15: everything off
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequencing FSM for the multicycle MIPS core.
// Inputs : clock, reset (async, active-high), opcode/funct from IR, ALU zero,
//          mem_ready (memory access completes), syscall_done.
// Outputs: datapath enables/selects (via mc_output_decode), syscall_req,
//          illegal_op pulse, and the raw state for debug.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  input  logic        syscall_done,
  output logic        pc_write,
  output logic        pc_write_cond,
  output logic        ir_write,
  output logic        reg_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        i_or_d,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        jal_link,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
  output logic [1:0]  pc_source,
  output logic        syscall_req,
  output logic        illegal_op,
  output logic [3:0]  state
);

  state_t cur, nxt;

  // Branch resolution happens in the datapath through pc_write_cond & zero,
  // so the FSM itself never looks at the flag.
  logic unused_zero;
  assign unused_zero = zero;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cur <= S_IDLE;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = S_FETCH;
    case (cur)
      S_IDLE:   nxt = S_FETCH;
      S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: nxt = S_MEMADR;
          OP_RTYPE: begin
            if      (funct == FN_JR)      nxt = S_JR;
            else if (funct == FN_SYSCALL) nxt = S_SYSCALL;
            else                          nxt = S_REX;
          end
          OP_BEQ:       nxt = S_BRANCH;
          OP_ADDI:      nxt = S_IEX;
          OP_J, OP_JAL: nxt = S_JUMP;
          default:      nxt = S_FETCH;  // illegal: trap pulse, refetch
        endcase
      end
      S_MEMADR:  nxt = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:   nxt = mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:   nxt = mem_ready ? S_FETCH : S_MEMWR;
      S_REX:     nxt = S_RWB;
      S_IEX:     nxt = S_IWB;
      S_SYSCALL: nxt = syscall_done ? S_FETCH : S_SYSCALL;
      default:   nxt = S_FETCH;  // single-cycle terminal states and code 15
    endcase
  end

  assign state = cur;

  mc_output_decode u_dec (
    .state         (cur),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .ir_write      (ir_write),
    .reg_write     (reg_write),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .i_or_d        (i_or_d),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .jal_link      (jal_link),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .alu_op        (alu_op),
    .pc_source     (pc_source),
    .syscall_req   (syscall_req),
    .illegal_op    (illegal_op)
  );

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// its state path and checks the control word at hand-derived points.
module tb_multicycle_control;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic [5:0] opcode = 6'h00;
  logic [5:0] funct = 6'h00;
  logic zero = 1'b0;
  logic mem_ready = 1'b1;
  logic syscall_done = 1'b0;

  logic pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write;
  logic i_or_d, reg_dst, mem_to_reg, jal_link, alu_src_a;
  logic [1:0] alu_src_b, alu_op, pc_source;
  logic syscall_req, illegal_op;
  logic [3:0] state;

  logic [18:0] outs;
  assign outs = {pc_write, pc_write_cond, ir_write, reg_write, mem_read, mem_write,
                 i_or_d, reg_dst, mem_to_reg, jal_link, alu_src_a,
                 alu_src_b, alu_op, pc_source, syscall_req, illegal_op};

  multicycle_control dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .syscall_done(syscall_done),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .ir_write(ir_write),
    .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
    .i_or_d(i_or_d), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .jal_link(jal_link), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_source(pc_source), .syscall_req(syscall_req),
    .illegal_op(illegal_op), .state(state)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi;
    logic [3:0] lw_path [5];
    lw_path = '{4'd2, 4'd3, 4'd4, 4'd5, 4'd1};

    // Reset state
    #2;
    check("rst_state", state, 0);
    check("rst_outs", outs, 0);
    #8 reset = 1'b0;               // t=10, between edges
    opcode = 6'h23;
    step();                        // IDLE -> FETCH
    check("first_fetch", state, 1);
    check("fetch_ir_write", ir_write, 1);
    check("fetch_pc_write", pc_write, 1);
    check("fetch_srcb", alu_src_b, 1);

    // lw, no wait-states: 2,3,4,5,1
    for (int i = 0; i < 5; i++) begin
      step();
      check($sformatf("lw_state%0d", i), state, lw_path[i]);
      check($sformatf("lw_regwr%0d", i), reg_write, (lw_path[i] == 4'd5));
      check($sformatf("lw_m2r%0d", i), mem_to_reg, (lw_path[i] == 4'd5));
      if (lw_path[i] == 4'd4) check("lw_memrd", {mem_read, i_or_d}, 2'b11);
    end

    // Fetch wait-state: IR/PC writes suppressed, stay in FETCH
    mem_ready = 1'b0;
    #1;
    check("fwait_ir", {ir_write, pc_write, mem_read}, 3'b001);
    step();
    check("fwait_state", state, 1);
    mem_ready = 1'b1;
    opcode = 6'h2B;
    #1;
    check("fdone_ir", ir_write, 1);

    // sw with two memory wait cycles
    step(); check("sw_decode", state, 2);
    check("decode_srcb", alu_src_b, 3);
    step(); check("sw_memadr", {alu_src_a, alu_src_b}, 3'b110);
    mem_ready = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("sw_wr_state%0d", i), state, 6);
      check($sformatf("sw_wr_en%0d", i), {mem_write, i_or_d}, 2'b11);
      if (i == 2) mem_ready = 1'b1;
      step();
    end
    check("sw_done", state, 1);
    check("sw_done_mw", mem_write, 0);

    // beq: 3 cycles regardless of zero
    opcode = 6'h04;
    for (int z = 0; z < 2; z++) begin
      zero = z[0];
      step(); check("beq_decode", state, 2);
      step(); check("beq_state", state, 9);
      check("beq_ctl", {alu_op, pc_write_cond, pc_source, alu_src_a}, 6'b01_1_01_1);
      step(); check("beq_back", state, 1);
    end

    // jal then j
    opcode = 6'h03;
    step(); step();
    check("jal_state", state, 10);
    check("jal_ctl", {pc_write, pc_source, reg_write, jal_link}, 5'b1_10_1_1);
    step(); check("jal_back", state, 1);
    opcode = 6'h02;
    step(); step();
    check("j_ctl", {pc_write, pc_source, reg_write, jal_link}, 5'b1_10_0_0);
    step();

    // jr
    opcode = 6'h00; funct = 6'h08;
    step(); step();
    check("jr_state", state, 13);
    check("jr_ctl", {pc_write, pc_source}, 3'b1_11);
    step(); check("jr_back", state, 1);

    // R-type add
    funct = 6'h20;
    step(); step();
    check("rex_state", state, 7);
    check("rex_ctl", {alu_op, alu_src_a, alu_src_b}, 5'b10_1_00);
    step(); check("rwb_ctl", {state, reg_write, reg_dst}, 6'b1000_1_1);
    step(); check("r_back", state, 1);

    // addi
    opcode = 6'h08;
    step(); step();
    check("iex_ctl", {state, alu_src_a, alu_src_b, alu_op}, 9'b1011_1_10_00);
    step(); check("iwb_ctl", {state, reg_write, reg_dst}, 6'b1100_1_0);
    step(); check("i_back", state, 1);

    // syscall with done on its 4th cycle
    opcode = 6'h00; funct = 6'h0C;
    step(); check("sys_decode_req", syscall_req, 0);
    step();
    hi = 0;
    for (int i = 0; i < 20 && state == 4'd14; i++) begin
      if (syscall_req) hi++;
      if (hi == 4) syscall_done = 1'b1;
      step();
    end
    syscall_done = 1'b0;
    check("sys_req_cycles", hi, 4);
    check("sys_back", state, 1);

    // syscall_done already high as SYSCALL is entered
    syscall_done = 1'b1;
    step(); check("sys2_decode", state, 2);
    step(); check("sys2_state", {state, syscall_req}, 5'b1110_1);
    step(); check("sys2_back", state, 1);
    syscall_done = 1'b0;

    // illegal opcode
    opcode = 6'h3F;
    step(); check("ill_pulse", {state, illegal_op}, 5'b0010_1);
    step(); check("ill_back", {state, illegal_op}, 5'b0001_0);

    // async reset in the middle of a stalled store
    opcode = 6'h2B;
    step(); step();
    mem_ready = 1'b0;
    step(); check("rst_mid_pre", mem_write, 1);
    #3 reset = 1'b1;
    #1;
    check("rst_mid_state", state, 0);
    check("rst_mid_outs", outs, 0);
    #2 reset = 1'b0;
    mem_ready = 1'b1;
    step(); check("rst_recover", state, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
